// File: rtl/alu_op_issue_pkg.sv
// Shared types and encodings for the ID->EX ALU issue stage.
// Holds the ALU operation codes, the MIPS opcode/funct encodings the
// decoder recognises, the registered bundle layout and small helpers.
package alu_op_issue_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned FIELD_W = 6;

  // ALU operation codes carried to EX
  localparam logic [OP_W-1:0] ALU_ADDU = 4'd0;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'd1;
  localparam logic [OP_W-1:0] ALU_SUBU = 4'd2;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd3;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd4;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd5;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd6;
  localparam logic [OP_W-1:0] ALU_NOR  = 4'd7;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd8;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd9;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'd10;

  // Primary opcodes (instr[31:26])
  localparam logic [FIELD_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [FIELD_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [FIELD_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [FIELD_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [FIELD_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [FIELD_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [FIELD_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [FIELD_W-1:0] OP_LW    = 6'h23;
  localparam logic [FIELD_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [FIELD_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FIELD_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FIELD_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FIELD_W-1:0] FN_SLLV = 6'h04;
  localparam logic [FIELD_W-1:0] FN_SRLV = 6'h06;
  localparam logic [FIELD_W-1:0] FN_SRAV = 6'h07;
  localparam logic [FIELD_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FIELD_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FIELD_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FIELD_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FIELD_W-1:0] FN_AND  = 6'h24;
  localparam logic [FIELD_W-1:0] FN_OR   = 6'h25;
  localparam logic [FIELD_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FIELD_W-1:0] FN_NOR  = 6'h27;

  // Registered EX bundle
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_W-1:0]  rd;
    logic              ovf_trap;
    logic              illegal;
  } alu_bundle_t;

  localparam alu_bundle_t BUNDLE_RESET = '{
    op:       ALU_ADDU,
    a:        '0,
    b:        '0,
    rd:       '0,
    ovf_trap: 1'b0,
    illegal:  1'b0
  };

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return DATA_W'(imm);
  endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational MIPS instruction decoder for the ALU issue stage.
// Ports:
//   instr    - instruction word
//   rs_val   - forwarded GPR[rs]
//   rt_val   - forwarded GPR[rt]
//   op       - ALU operation code
//   a, b     - ALU inputA / inputB
//   rd       - writeback register, 0 when none
//   ovf_trap - signed overflow must be checked (ADD, SUB, ADDI)
//   illegal  - instruction cannot execute on the ALU
module alu_instr_decode
  import alu_op_issue_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [REG_W-1:0]  rd,
  output logic              ovf_trap,
  output logic              illegal
);

  logic [FIELD_W-1:0] opcode;
  logic [FIELD_W-1:0] funct;
  logic [REG_W-1:0]   rt_f;
  logic [REG_W-1:0]   rd_f;
  logic [SHAMT_W-1:0] shamt;
  logic [IMM_W-1:0]   imm;
  logic               unused_rs_field;

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // Register numbers of rs are resolved upstream; only the value is used here.
  assign unused_rs_field = ^instr[25:21];

  // Decode; anything unrecognised falls through as an illegal ALU NOP.
  // rd naturally comes out 0 when the decoded destination is $0.
  always_comb begin
    op       = ALU_ADDU;
    a        = '0;
    b        = '0;
    rd       = '0;
    ovf_trap = 1'b0;
    illegal  = 1'b1;

    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            a       = rs_val;
            b       = rt_val;
            rd      = rd_f;
            illegal = 1'b0;
            case (funct)
              FN_ADD:  begin op = ALU_ADD; ovf_trap = 1'b1; end
              FN_ADDU: op = ALU_ADDU;
              FN_SUB:  begin op = ALU_SUB; ovf_trap = 1'b1; end
              FN_SUBU: op = ALU_SUBU;
              FN_AND:  op = ALU_AND;
              FN_OR:   op = ALU_OR;
              FN_XOR:  op = ALU_XOR;
              default: op = ALU_NOR;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            a       = DATA_W'(shamt);
            b       = rt_val;
            rd      = rd_f;
            illegal = 1'b0;
            case (funct)
              FN_SLL:  op = ALU_SLL;
              FN_SRL:  op = ALU_SRL;
              default: op = ALU_SRA;
            endcase
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            // Variable shifts only honour the low 5 bits of rs.
            a       = DATA_W'(rs_val[SHAMT_W-1:0]);
            b       = rt_val;
            rd      = rd_f;
            illegal = 1'b0;
            case (funct)
              FN_SLLV: op = ALU_SLL;
              FN_SRLV: op = ALU_SRL;
              default: op = ALU_SRA;
            endcase
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        op       = ALU_ADD;
        a        = rs_val;
        b        = sext_imm(imm);
        rd       = rt_f;
        ovf_trap = 1'b1;
        illegal  = 1'b0;
      end
      OP_ADDIU: begin
        op      = ALU_ADDU;
        a       = rs_val;
        b       = sext_imm(imm);
        rd      = rt_f;
        illegal = 1'b0;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        a       = rs_val;
        b       = zext_imm(imm);
        rd      = rt_f;
        illegal = 1'b0;
        case (opcode)
          OP_ANDI: op = ALU_AND;
          OP_ORI:  op = ALU_OR;
          default: op = ALU_XOR;
        endcase
      end
      OP_LUI: begin
        // Upper-immediate load expressed as imm << 16 on the shifter.
        op      = ALU_SLL;
        a       = DATA_W'(16);
        b       = zext_imm(imm);
        rd      = rt_f;
        illegal = 1'b0;
      end
      OP_LW, OP_SW: begin
        // Address generation; only loads write back.
        op      = ALU_ADDU;
        a       = rs_val;
        b       = sext_imm(imm);
        rd      = (opcode == OP_LW) ? rt_f : '0;
        illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID->EX issue stage: decodes an instruction plus operand values into an
// ALU bundle and registers it for EX behind a valid/ready handshake.
// A second (skid) entry absorbs one bundle while EX stalls, so in_ready is
// a register and never depends combinationally on out_ready.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - upstream handshake
//   in_instr            - instruction word
//   in_rs_val/in_rt_val - forwarded GPR[rs] / GPR[rt]
//   in_flush            - drop all held and incoming bundles
//   out_valid/out_ready - EX handshake
//   out_op/out_a/out_b  - ALU operation and operands
//   out_rd              - writeback register (0 = none)
//   out_ovf_trap        - signed overflow check required
//   out_illegal         - instruction not executable on the ALU
module alu_op_issue
  import alu_op_issue_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ENABLE_SKID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_rs_val,
  input  logic [XLEN-1:0] in_rt_val,
  input  logic            in_flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_op,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_rd,
  output logic            out_ovf_trap,
  output logic            out_illegal
);

  localparam bit SKID_ON = (ENABLE_SKID != 0);

  logic [OP_W-1:0]   dec_op;
  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;
  logic [REG_W-1:0]  dec_rd;
  logic              dec_ovf_trap;
  logic              dec_illegal;
  alu_bundle_t       dec_bundle;

  alu_bundle_t main_q, main_d;
  alu_bundle_t skid_q, skid_d;
  logic        main_valid_q, main_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        in_fire;
  logic        out_fire;

  alu_instr_decode u_decode (
    .instr    (in_instr),
    .rs_val   (in_rs_val),
    .rt_val   (in_rt_val),
    .op       (dec_op),
    .a        (dec_a),
    .b        (dec_b),
    .rd       (dec_rd),
    .ovf_trap (dec_ovf_trap),
    .illegal  (dec_illegal)
  );

  assign dec_bundle = '{
    op:       dec_op,
    a:        dec_a,
    b:        dec_b,
    rd:       dec_rd,
    ovf_trap: dec_ovf_trap,
    illegal:  dec_illegal
  };

  // Without the skid entry the stage degenerates to a single pipe register
  // whose ready follows the consumer directly.
  assign in_ready = SKID_ON ? in_ready_q
                            : (~reset & (out_ready | ~main_valid_q));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= BUNDLE_RESET;
      skid_q       <= BUNDLE_RESET;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Next-state: FIFO order main -> EX, skid refills main on each output
  // transfer. in_fire implies the skid is empty, since in_ready tracks it.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (in_flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d = dec_bundle;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (main_valid_q) begin
        skid_d       = dec_bundle;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = dec_bundle;
        main_valid_d = 1'b1;
      end
    end

    in_ready_d = ~skid_valid_d;
  end

  // Outputs straight from the main register
  always_comb begin
    out_valid    = main_valid_q;
    out_op       = main_q.op;
    out_a        = main_q.a;
    out_b        = main_q.b;
    out_rd       = main_q.rd;
    out_ovf_trap = main_q.ovf_trap;
    out_illegal  = main_q.illegal;
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue.
module tb_alu_op_issue;
  import alu_op_issue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        in_flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        out_ovf_trap;
  logic        out_illegal;

  int tests  = 0;
  int failed = 0;

  alu_op_issue #(.XLEN(32), .ENABLE_SKID(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_rs_val    (in_rs_val),
    .in_rt_val    (in_rt_val),
    .in_flush     (in_flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op       (out_op),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_rd       (out_rd),
    .out_ovf_trap (out_ovf_trap),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic trap, input logic ill);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".op"},    32'(out_op), 32'(op));
    chk({tag, ".a"},     out_a, a);
    chk({tag, ".b"},     out_b, b);
    chk({tag, ".rd"},    32'(out_rd), 32'(rd));
    chk({tag, ".trap"},  32'(out_ovf_trap), 32'(trap));
    chk({tag, ".ill"},   32'(out_illegal), 32'(ill));
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_rs_val = rs;
    in_rt_val = rt;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_rs_val = '0;
    in_rt_val = '0;
    in_flush  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.op", 32'(out_op), 32'(ALU_ADDU));
    chk("rst.a", out_a, 32'd0);
    chk("rst.rd", 32'(out_rd), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);
    chk("post_rst.out_valid", 32'(out_valid), 32'd0);

    // Streaming decode, out_ready held high
    drive(32'h2128FFFF, 32'd5, 32'd0);                 // ADDI $8,$9,-1
    step(); chk_out("addi", ALU_ADD, 32'd5, 32'hFFFFFFFF, 5'd8, 1'b1, 1'b0);
    drive(32'h3C021234, 32'h0, 32'h0);                 // LUI $2,0x1234
    step(); chk_out("lui", ALU_SLL, 32'd16, 32'h00001234, 5'd2, 1'b0, 1'b0);
    drive(32'h00A41804, 32'h25, 32'hDEADBEEF);         // SLLV $3,$4,$5
    step(); chk_out("sllv", ALU_SLL, 32'd5, 32'hDEADBEEF, 5'd3, 1'b0, 1'b0);
    drive(32'h0022182A, 32'h1234, 32'h5678);           // SLT
    step(); chk_out("slt", ALU_ADDU, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    drive(32'h00220018, 32'h1234, 32'h5678);           // MULT
    step(); chk_out("mult", ALU_ADDU, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    drive(32'hFFFFFFFF, 32'h1234, 32'h5678);           // opcode 0x3F
    step(); chk_out("op3f", ALU_ADDU, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    drive(32'h00220020, 32'd7, 32'd9);                 // ADD $0,$1,$2
    step(); chk_out("add_r0", ALU_ADD, 32'd7, 32'd9, 5'd0, 1'b1, 1'b0);
    drive(32'h0022F823, 32'd100, 32'd3);               // SUBU $31,$1,$2
    step(); chk_out("subu", ALU_SUBU, 32'd100, 32'd3, 5'd31, 1'b0, 1'b0);
    drive(32'h8D28FFFC, 32'h1000, 32'h0);              // LW $8,-4($9)
    step(); chk_out("lw", ALU_ADDU, 32'h1000, 32'hFFFFFFFC, 5'd8, 1'b0, 1'b0);
    drive(32'hAD280010, 32'h2000, 32'hAAAA);           // SW $8,16($9)
    step(); chk_out("sw", ALU_ADDU, 32'h2000, 32'h00000010, 5'd0, 1'b0, 1'b0);
    drive(32'h34C58001, 32'h0F0F0000, 32'h0);          // ORI $5,$6,0x8001
    step(); chk_out("ori", ALU_OR, 32'h0F0F0000, 32'h00008001, 5'd5, 1'b0, 1'b0);
    drive(32'h000838C3, 32'h0, 32'h80000000);          // SRA $7,$8,3
    step(); chk_out("sra", ALU_SRA, 32'd3, 32'h80000000, 5'd7, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    chk("drain.in_ready", 32'(in_ready), 32'd1);

    // Back-pressure: two bundles held, FIFO release
    out_ready = 1'b0;
    drive(32'h302200F0, 32'h11, 32'h0);                // I1 ANDI $2,$1,0xF0
    step(); chk_out("bp.i1", ALU_AND, 32'h11, 32'h000000F0, 5'd2, 1'b0, 1'b0);
    chk("bp.rdy_after_i1", 32'(in_ready), 32'd1);
    drive(32'h38230F0F, 32'h22, 32'h0);                // I2 XORI $3,$1,0x0F0F
    step(); chk_out("bp.i1_hold", ALU_AND, 32'h11, 32'h000000F0, 5'd2, 1'b0, 1'b0);
    chk("bp.rdy_after_i2", 32'(in_ready), 32'd0);
    drive(32'h24248000, 32'h33, 32'h0);                // I3 ADDIU $4,$1,-32768
    step(); chk_out("bp.i1_stable", ALU_AND, 32'h11, 32'h000000F0, 5'd2, 1'b0, 1'b0);
    chk("bp.rdy_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step(); chk_out("bp.i2", ALU_XOR, 32'h22, 32'h00000F0F, 5'd3, 1'b0, 1'b0);
    chk("bp.rdy_reopen", 32'(in_ready), 32'd1);
    step(); chk_out("bp.i3", ALU_ADDU, 32'h33, 32'hFFFF8000, 5'd4, 1'b0, 1'b0);

    // Flush with both entries full
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step(); chk_out("fl.hold", ALU_ADDU, 32'h33, 32'hFFFF8000, 5'd4, 1'b0, 1'b0);
    drive(32'h302200F0, 32'h11, 32'h0);
    step();
    chk("fl.full_rdy", 32'(in_ready), 32'd0);
    in_flush  = 1'b1;
    out_ready = 1'b1;
    drive(32'h38230F0F, 32'h22, 32'h0);
    step();
    chk("fl.out_valid", 32'(out_valid), 32'd0);
    chk("fl.in_ready", 32'(in_ready), 32'd1);
    in_flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fl.no_emit", 32'(out_valid), 32'd0);
    chk("fl.in_ready2", 32'(in_ready), 32'd1);
    drive(32'h24248000, 32'h44, 32'h0);
    step(); chk_out("fl.resume", ALU_ADDU, 32'h44, 32'hFFFF8000, 5'd4, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();
    chk("fl.drain", 32'(out_valid), 32'd0);

    // Reset with two bundles held
    out_ready = 1'b0;
    drive(32'h302200F0, 32'h11, 32'h0);
    step();
    drive(32'h38230F0F, 32'h22, 32'h0);
    step();
    chk("rr.full_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    chk("rr.in_ready", 32'(in_ready), 32'd0);
    chk("rr.out_valid", 32'(out_valid), 32'd0);
    chk("rr.op", 32'(out_op), 32'(ALU_ADDU));
    chk("rr.a", out_a, 32'd0);
    chk("rr.b", out_b, 32'd0);
    chk("rr.rd", 32'(out_rd), 32'd0);
    chk("rr.trap", 32'(out_ovf_trap), 32'd0);
    chk("rr.ill", 32'(out_illegal), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rr.rdy_after", 32'(in_ready), 32'd1);
    chk("rr.valid_after", 32'(out_valid), 32'd0);
    step();
    chk("rr.no_ghost", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
